xbar_switch_n: RTL and testbench

XBAR_SWITCH_N -- requirements
Module: xbar_switch_n

---
 rtl/xbar_pkg.sv | 26 ++
 rtl/xbar_rr_arb.sv | 53 +++++
 rtl/xbar_switch_n.sv | 139 +++++++++++++
 tb/tb_xbar_switch_n.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// ============================================================================
// Module      : xbar_pkg
// Description : Shared defaults and helper function for the NxN crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xbar_pkg;

    localparam int NPORT_DEF = 4;
    localparam int DW_DEF    = 4;
    localparam int DEPTH_DEF = 2;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xbar_rr_arb.sv
// ============================================================================
// Module      : xbar_rr_arb
// Description : N-request round-robin arbiter, one-hot grant, pointer register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_rr_arb
    import xbar_pkg::*;
#(
    parameter int N = NPORT_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx_w;
    logic          found_w;

    // N is a power of two, so the pointer arithmetic wraps naturally
    always_comb begin
        gnt_o   = '0;
        ptr_d   = ptr_q;
        found_w = 1'b0;
        idx_w   = ptr_q;
        for (int k = 0; k < N; k++) begin
            idx_w = ptr_q + PW'(k);
            if (en_i && !found_w && req_i[idx_w]) begin
                gnt_o[idx_w] = 1'b1;
                ptr_d        = idx_w + PW'(1);
                found_w      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/xbar_switch_n.sv
// ============================================================================
// Module      : xbar_switch_n
// Description : NxN crossbar with per-input FIFOs and per-output RR arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_switch_n
    import xbar_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = clog2(NPORT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NPORT-1:0]    Y_validtx,
    input  logic [NPORT*AW-1:0] Y_adr_i,
    input  logic [NPORT*DW-1:0] Y_dat_i,
    output logic [NPORT-1:0]    Y_acktx,
    output logic [NPORT*DW-1:0] X_dat_o,
    output logic [NPORT-1:0]    X_validrx,
    input  logic [NPORT-1:0]    X_ackrx,
    output logic [NPORT-1:0]    valids
);

    localparam int EW      = AW + DW;
    localparam int ENTRIES = 2 ** DEPTH;
    localparam int CW      = DEPTH + 1;

    logic [AW-1:0]    head_adr_w [NPORT];
    logic [DW-1:0]    head_dat_w [NPORT];
    logic [NPORT-1:0] nempty_w;
    logic [NPORT-1:0] pop_w;
    logic [NPORT-1:0] req_w      [NPORT];
    logic [NPORT-1:0] gnt_w      [NPORT];
    logic [DW-1:0]    gdat_w     [NPORT];

    // req_w[j][i]: head of FIFO i is addressed to output j
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                req_w[j][i] = nempty_w[i] && (head_adr_w[i] == AW'(j));
            end
        end
    end

    always_comb begin
        pop_w = '0;
        for (int j = 0; j < NPORT; j++) begin
            gdat_w[j] = '0;
            for (int i = 0; i < NPORT; i++) begin
                pop_w[i] = pop_w[i] | gnt_w[j][i];
                if (gnt_w[j][i]) begin
                    gdat_w[j] = gdat_w[j] | head_dat_w[i];
                end
            end
        end
    end

    for (genvar i = 0; i < NPORT; i++) begin : g_fifo
        logic [EW-1:0]    mem_q [ENTRIES];
        logic [DEPTH-1:0] wptr_q;
        logic [DEPTH-1:0] rptr_q;
        logic [CW-1:0]    cnt_q;
        logic             full_w;
        logic             push_w;

        assign full_w        = (cnt_q == CW'(ENTRIES));
        assign Y_acktx[i]    = ~full_w & ~rst_i;
        assign push_w        = Y_validtx[i] & Y_acktx[i];
        assign nempty_w[i]   = (cnt_q != '0);
        assign valids[i]     = nempty_w[i];
        assign head_adr_w[i] = mem_q[rptr_q][EW-1:DW];
        assign head_dat_w[i] = mem_q[rptr_q][DW-1:0];

        always_ff @(posedge clk_i) begin
            if (push_w) begin
                mem_q[wptr_q] <= {Y_adr_i[i*AW +: AW], Y_dat_i[i*DW +: DW]};
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push_w) begin
                    wptr_q <= wptr_q + DEPTH'(1);
                end
                if (pop_w[i]) begin
                    rptr_q <= rptr_q + DEPTH'(1);
                end
                case ({push_w, pop_w[i]})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    for (genvar j = 0; j < NPORT; j++) begin : g_out
        logic          ovalid_q;
        logic [DW-1:0] odat_q;
        logic          free_w;

        assign free_w              = ~ovalid_q | X_ackrx[j];
        assign X_validrx[j]        = ovalid_q;
        assign X_dat_o[j*DW +: DW] = odat_q;

        xbar_rr_arb #(
            .N (NPORT)
        ) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (free_w),
            .req_i (req_w[j]),
            .gnt_o (gnt_w[j])
        );

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ovalid_q <= 1'b0;
                odat_q   <= '0;
            end else if (free_w) begin
                ovalid_q <= |gnt_w[j];
                if (|gnt_w[j]) begin
                    odat_q <= gdat_w[j];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xbar_switch_n.sv
// ============================================================================
// Module      : tb_xbar_switch_n
// Description : Self-checking bench for xbar_switch_n against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xbar_switch_n;

    localparam int NP = 4;
    localparam int DW = 4;
    localparam int AW = 2;

    logic             clk_i;
    logic             rst_i;
    logic [NP-1:0]    Y_validtx;
    logic [NP*AW-1:0] Y_adr_i;
    logic [NP*DW-1:0] Y_dat_i;
    logic [NP-1:0]    Y_acktx;
    logic [NP*DW-1:0] X_dat_o;
    logic [NP-1:0]    X_validrx;
    logic [NP-1:0]    X_ackrx;
    logic [NP-1:0]    valids;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    xbar_switch_n #(
        .NPORT (NP),
        .DW    (DW),
        .DEPTH (2)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .Y_validtx (Y_validtx),
        .Y_adr_i   (Y_adr_i),
        .Y_dat_i   (Y_dat_i),
        .Y_acktx   (Y_acktx),
        .X_dat_o   (X_dat_o),
        .X_validrx (X_validrx),
        .X_ackrx   (X_ackrx),
        .valids    (valids)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: per-input queues, per-output register, RR pointers
    logic [AW+DW-1:0] mq [NP][$];
    bit               mov [NP];
    logic [DW-1:0]    mod [NP];
    int               mptr [NP];

    always @(posedge clk_i) begin : model
        int gi [NP];
        bit fr [NP];
        bit acc [NP];
        int i;
        logic [AW+DW-1:0] h;
        if (rst_i) begin
            for (int n = 0; n < NP; n++) begin
                mq[n].delete();
                mov[n]  = 1'b0;
                mod[n]  = '0;
                mptr[n] = 0;
            end
        end else begin
            for (int n = 0; n < NP; n++) begin
                acc[n] = Y_validtx[n] && (mq[n].size() < 4);
                fr[n]  = !mov[n] || X_ackrx[n];
                gi[n]  = -1;
            end
            for (int j = 0; j < NP; j++) begin
                if (fr[j]) begin
                    for (int k = 0; k < NP; k++) begin
                        i = (mptr[j] + k) % NP;
                        if (gi[j] < 0 && mq[i].size() > 0) begin
                            h = mq[i][0];
                            if (int'(h[AW+DW-1:DW]) == j) gi[j] = i;
                        end
                    end
                    if (gi[j] >= 0) begin
                        h       = mq[gi[j]][0];
                        mov[j]  = 1'b1;
                        mod[j]  = h[DW-1:0];
                        mptr[j] = (gi[j] + 1) % NP;
                    end else begin
                        mov[j] = 1'b0;
                    end
                end
            end
            for (int j = 0; j < NP; j++) begin
                if (gi[j] >= 0) void'(mq[gi[j]].pop_front());
            end
            for (int n = 0; n < NP; n++) begin
                if (acc[n]) mq[n].push_back({Y_adr_i[n*AW +: AW], Y_dat_i[n*DW +: DW]});
            end
        end
    end

    always @(negedge clk_i) begin : compare
        logic [NP-1:0] e_ack;
        logic [NP-1:0] e_val;
        if (chk_en) begin
            for (int n = 0; n < NP; n++) begin
                e_ack[n] = !rst_i && (mq[n].size() < 4);
                e_val[n] = (mq[n].size() != 0);
                chk("m_validrx", 32'(X_validrx[n]), 32'(mov[n]));
                if (mov[n]) chk("m_dat", 32'(X_dat_o[n*DW +: DW]), 32'(mod[n]));
            end
            chk("m_acktx", 32'(Y_acktx), 32'(e_ack));
            chk("m_valids", 32'(valids), 32'(e_val));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        Y_validtx = '0;
        Y_adr_i   = '0;
        Y_dat_i   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        idle_inputs();
        X_ackrx = '1;
        for (int c = 0; c < max_cycles; c++) begin
            if (valids == '0 && X_validrx == '0) break;
            tick();
        end
        chk("drain", 32'({valids, X_validrx}), 32'h0);
    endtask

    initial begin
        rst_i   = 1'b1;
        X_ackrx = '1;
        idle_inputs();
        tick();
        chk_en = 1'b1;
        chk("acktx_in_reset", 32'(Y_acktx), 32'h0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("acktx_after_reset", 32'(Y_acktx), 32'hF);
        chk("valids_reset", 32'(valids), 32'h0);
        chk("validrx_reset", 32'(X_validrx), 32'h0);
        chk("dat_reset", 32'(X_dat_o), 32'h0);

        // Single word, input 0 -> output 2, two-cycle latency, one-cycle pulse
        Y_validtx = 4'b0001;
        Y_adr_i   = 8'b0000_0010;
        Y_dat_i   = 16'h000A;
        tick();
        idle_inputs();
        chk("lat_t1_novalid", 32'(X_validrx), 32'h0);
        tick();
        chk("lat_t2_valid", 32'(X_validrx), 32'b0100);
        chk("lat_t2_dat", 32'(X_dat_o[8 +: 4]), 32'hA);
        tick();
        chk("lat_t3_gone", 32'(X_validrx), 32'h0);

        // All inputs target output 1: RR order 0,1,2,3,... one word per cycle
        do_reset();
        Y_validtx = 4'b1111;
        Y_adr_i   = 8'b0101_0101;
        Y_dat_i   = 16'h3210;
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("rr_valid", 32'(X_validrx[1]), 32'h1);
            chk("rr_src", 32'(X_dat_o[4 +: 4]), 32'(k % 4));
            tick();
        end
        drain(60);

        // Input 1 fills to output 3 with its sink stalled
        do_reset();
        X_ackrx = 4'b0111;
        Y_adr_i = 8'b0000_1100;
        for (int w = 1; w <= 5; w++) begin
            Y_validtx = 4'b0010;
            Y_dat_i   = 16'(w << 4);
            #1;
            chk("fill_ack", 32'(Y_acktx[1]), 32'h1);
            tick();
        end
        Y_dat_i = 16'h0060;
        #1;
        chk("full_noack", 32'(Y_acktx[1]), 32'h0);
        chk("full_hold_valid", 32'(X_validrx[3]), 32'h1);
        chk("full_hold_dat", 32'(X_dat_o[12 +: 4]), 32'h1);
        chk("full_valids", 32'(valids), 32'b0010);
        idle_inputs();
        X_ackrx = '1;
        for (int n = 1; n <= 5; n++) begin
            #1;
            chk("order_valid", 32'(X_validrx[3]), 32'h1);
            chk("order_dat", 32'(X_dat_o[12 +: 4]), 32'(n));
            tick();
        end
        chk("order_end", 32'(X_validrx[3]), 32'h0);

        // Output 0 stalled for 3 cycles holding 5
        do_reset();
        X_ackrx   = 4'b1110;
        Y_validtx = 4'b0100;
        Y_adr_i   = 8'b0000_0000;
        Y_dat_i   = 16'h0500;
        tick();
        idle_inputs();
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("hold_valid", 32'(X_validrx[0]), 32'h1);
            chk("hold_dat", 32'(X_dat_o[0 +: 4]), 32'h5);
            tick();
        end
        X_ackrx = '1;
        tick();
        chk("hold_released", 32'(X_validrx[0]), 32'h0);

        // Reset with words buffered: nothing stale emerges
        do_reset();
        X_ackrx   = 4'b1011;
        Y_adr_i   = 8'b1000_0000;
        for (int w = 1; w <= 4; w++) begin
            Y_validtx = 4'b1000;
            Y_dat_i   = 16'(w << 12);
            tick();
        end
        idle_inputs();
        chk("pre_rst_valids", 32'(valids), 32'b1000);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_acktx", 32'(Y_acktx), 32'h0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("post_rst_valids", 32'(valids), 32'h0);
        chk("post_rst_validrx", 32'(X_validrx), 32'h0);
        chk("post_rst_acktx", 32'(Y_acktx), 32'hF);
        X_ackrx = '1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("no_stale", 32'(X_validrx), 32'h0);
        end

        // Mixed traffic and sink stalls, checked by the model each cycle
        for (int c = 0; c < 60; c++) begin
            Y_validtx = 4'($urandom);
            Y_adr_i   = 8'($urandom);
            Y_dat_i   = 16'($urandom);
            X_ackrx   = 4'($urandom);
            tick();
        end
        drain(80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
